// File: rtl/serial_frame_pkg.sv
// Shared types and default constants for the serial frame receiver.
package serial_frame_pkg;

  // Receiver FSM states; the spare encoding 2'd3 is steered back to HUNT.
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_BAD  = 2'd3
  } rx_state_t;

  localparam int         DEF_WIDTH    = 8;
  localparam int         DEF_SYNC_LEN = 4;
  localparam logic [3:0] DEF_SYNC_PAT = 4'b1011;

endpackage

// File: rtl/serial_shift_in.sv
// N-bit serial-in / parallel-out shift register, first bit received ends up in the MSB.
module serial_shift_in
  import serial_frame_pkg::*;
#(
  parameter int N = DEF_SYNC_LEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift,
  input  logic         din,
  output logic [N-1:0] q
);

  // Shift the new bit into the LSB; a synchronous clear wins over shifting.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift) begin
      q <= {q[N-2:0], din};
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync pattern, shifts in one data word plus
// a parity bit, then presents the word with a one-cycle valid pulse.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int                  WIDTH      = DEF_WIDTH,
  parameter int                  SYNC_LEN   = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT   = SYNC_LEN'(DEF_SYNC_PAT),
  parameter bit                  ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             parity_err,
  output logic             locked
);

  localparam int FW = $clog2(SYNC_LEN + 1);
  localparam int CW = $clog2(WIDTH);

  localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_LEN);
  localparam logic [FW-1:0] FILL_MIN = FW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  rx_state_t          state, state_next;
  logic [SYNC_LEN-1:0] sreg;
  logic [WIDTH-1:0]    dreg;
  logic [FW-1:0]       fill;
  logic [CW-1:0]       cnt;

  logic sync_shift;
  logic sync_clr;
  logic data_shift;
  logic frame_done;
  logic sync_hit;
  logic exp_par;
  logic sync_unused_msb;

  // The oldest sync bit falls out of the match window, which is the last
  // SYNC_LEN-1 stored bits plus the bit arriving on this edge.
  assign sync_unused_msb = sreg[SYNC_LEN-1];
  assign sync_hit = (fill >= FILL_MIN) && ({sreg[SYNC_LEN-2:0], din} == SYNC_PAT);

  assign exp_par = ODD_PARITY ? ~^dreg : ^dreg;

  serial_shift_in #(.N(SYNC_LEN)) u_sync_reg (
    .clk   (clk),
    .rst   (rst),
    .clr   (sync_clr),
    .shift (sync_shift),
    .din   (din),
    .q     (sreg)
  );

  serial_shift_in #(.N(WIDTH)) u_data_reg (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .shift (data_shift),
    .din   (din),
    .q     (dreg)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_next = state;
    sync_shift = 1'b0;
    sync_clr   = 1'b0;
    data_shift = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_HUNT: begin
        sync_shift = 1'b1;
        if (sync_hit) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        data_shift = 1'b1;
        if (cnt == CNT_LAST) begin
          state_next = ST_PAR;
        end
      end
      ST_PAR: begin
        // Parity bit never seeds the next sync search.
        frame_done = 1'b1;
        sync_clr   = 1'b1;
        state_next = ST_HUNT;
      end
      default: begin
        sync_clr   = 1'b1;
        state_next = ST_HUNT;
      end
    endcase
  end

  // Sync fill count: saturates at SYNC_LEN, restarts whenever the sync reg is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else if (sync_clr) begin
      fill <= '0;
    end else if (sync_shift && (fill != FILL_MAX)) begin
      fill <= fill + 1'b1;
    end
  end

  // Data bit count: held at zero while hunting, advances once per data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_HUNT) begin
      cnt <= '0;
    end else if (data_shift) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Output word, parity flag and valid pulse, all updated on the parity edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      parity_err <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= frame_done;
      if (frame_done) begin
        dout       <= dreg;
        parity_err <= (din != exp_par);
      end
    end
  end

  // Lock indicator trails the FSM by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
    end else begin
      locked <= (state == ST_DATA) || (state == ST_PAR);
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (WIDTH=8, SYNC_LEN=4, SYNC_PAT=1011, even parity).
module tb_serial_frame_rx;

  logic       clk;
  logic       rst;
  logic       din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       parity_err;
  logic       locked;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int valid_cycle;
  int first_valid_cycle;

  logic [7:0] exp_dout = 8'h00;
  logic       exp_perr = 1'b0;

  serial_frame_rx #(
    .WIDTH      (8),
    .SYNC_LEN   (4),
    .SYNC_PAT   (4'b1011),
    .ODD_PARITY (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .parity_err (parity_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one bit away from the active edge, then sample 1 time unit after it.
  task automatic tick(input logic b);
    @(negedge clk);
    din = b;
    @(posedge clk);
    cycle++;
    #1;
  endtask

  // Idle/noise bit: no frame can complete and the receiver is not locked.
  task automatic quiet_bit(input logic b, input string tag);
    tick(b);
    check({tag, "_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  // Send the first nbits of a frame: sync 1011, data MSB first, parity bit.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic err,
                            input int nbits, input string tag);
    logic [12:0] bits;
    bits = {4'b1011, data, par};
    for (int k = 1; k <= nbits; k++) begin
      tick(bits[13-k]);
      check($sformatf("%s_valid%0d", tag, k), 32'(dout_valid), (k == 13) ? 32'd1 : 32'd0);
      check($sformatf("%s_locked%0d", tag, k), 32'(locked), (k >= 5) ? 32'd1 : 32'd0);
      if (k == 13) begin
        exp_dout    = data;
        exp_perr    = err;
        valid_cycle = cycle;
      end
      check($sformatf("%s_dout%0d", tag, k), 32'(dout), 32'(exp_dout));
      check($sformatf("%s_perr%0d", tag, k), 32'(parity_err), 32'(exp_perr));
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;

    // 1: reset held two cycles with din toggling
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      din = ~din;
      @(posedge clk);
      #1;
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_valid", 32'(dout_valid), 32'd0);
      check("rst_perr", 32'(parity_err), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    din = 1'b0;

    // 2: good frame C3, parity 0 (four ones -> even)
    send_frame(8'hC3, 1'b0, 1'b0, 13, "good");
    quiet_bit(1'b0, "good_after");
    quiet_bit(1'b0, "gap2");

    // 3: same frame with wrong parity bit
    send_frame(8'hC3, 1'b1, 1'b1, 13, "badpar");
    quiet_bit(1'b0, "badpar_after");
    quiet_bit(1'b0, "gap3");

    // 4: noise 0,0,1,1,1 contains no 1011 window before the real sync
    quiet_bit(1'b0, "noise0");
    quiet_bit(1'b0, "noise1");
    quiet_bit(1'b1, "noise2");
    quiet_bit(1'b1, "noise3");
    quiet_bit(1'b1, "noise4");
    send_frame(8'h5A, 1'b0, 1'b0, 13, "noisy");
    quiet_bit(1'b0, "noisy_after");

    // 5: reset after sync plus four data bits discards the partial frame
    send_frame(8'hFF, 1'b0, 1'b0, 8, "partial");
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_dout = 8'h00;
    exp_perr = 1'b0;
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_valid", 32'(dout_valid), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    @(posedge clk);
    cycle++;
    #1;
    check("midrst_hold_locked", 32'(locked), 32'd0);
    check("midrst_hold_valid", 32'(dout_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    din = 1'b0;
    send_frame(8'hFF, 1'b0, 1'b0, 13, "after_rst");
    quiet_bit(1'b0, "after_rst_idle");

    // 6: back-to-back frames 01 and 80, each with parity 1
    send_frame(8'h01, 1'b1, 1'b0, 13, "b2b_a");
    first_valid_cycle = valid_cycle;
    send_frame(8'h80, 1'b1, 1'b0, 13, "b2b_b");
    check("b2b_spacing", 32'(valid_cycle - first_valid_cycle), 32'd13);
    quiet_bit(1'b0, "b2b_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
